frame_binarizer: RTL

//  Upstream stage of erosion_dilation. Accepts an RGB565 pixel stream, classifies each pixel against a
//  per-channel colour window, packs a row into one IMG_W-bit word (bit x = column x) and writes it to the

---
 rtl/bin_frame_pkg.sv | 30 +++
 rtl/rgb565_window.sv | 28 ++
 rtl/frame_binarizer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bin_frame_pkg.sv
// Shared constants and FSM encoding for the binary-frame path (frame_binarizer -> erosion_dilation).
package bin_frame_pkg;

  localparam int IMG_W  = 640;
  localparam int IMG_H  = 480;
  localparam int ADDR_W = 9;
  localparam int PIX_W  = 16;

  // RGB565 field positions within a pixel word
  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;
  localparam int R_W  = R_HI - R_LO + 1;
  localparam int G_W  = G_HI - G_LO + 1;
  localparam int B_W  = B_HI - B_LO + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SOF  = 3'd1,
    CAPTURE   = 3'd2,
    WRITE_ROW = 3'd3,
    HANDOFF   = 3'd4,
    RUN       = 3'd5,
    DONE      = 3'd6
  } state_e;

endpackage

// File: rtl/rgb565_window.sv
// Combinational colour-window classifier: 1 when every RGB565 channel lies inside its inclusive bounds.
module rgb565_window
  import bin_frame_pkg::*;
(
  input  logic [PIX_W-1:0] pix_data,
  input  logic [R_W-1:0]   r_min,
  input  logic [R_W-1:0]   r_max,
  input  logic [G_W-1:0]   g_min,
  input  logic [G_W-1:0]   g_max,
  input  logic [B_W-1:0]   b_min,
  input  logic [B_W-1:0]   b_max,
  output logic             hit
);

  logic [R_W-1:0] r;
  logic [G_W-1:0] g;
  logic [B_W-1:0] b;

  assign r = pix_data[R_HI:R_LO];
  assign g = pix_data[G_HI:G_LO];
  assign b = pix_data[B_HI:B_LO];

  // An inverted window (min > max) can never be satisfied, so it classifies everything as 0.
  assign hit = (r >= r_min) && (r <= r_max) &&
               (g >= g_min) && (g <= g_max) &&
               (b >= b_min) && (b <= b_max);

endmodule

// File: rtl/frame_binarizer.sv
// Binarises an RGB565 frame row by row into the shared BRAM, then hands the BRAM to erosion_dilation.
module frame_binarizer #(
  parameter int IMG_W  = bin_frame_pkg::IMG_W,
  parameter int IMG_H  = bin_frame_pkg::IMG_H,
  parameter int ADDR_W = bin_frame_pkg::ADDR_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [bin_frame_pkg::R_W-1:0]   r_min,
  input  logic [bin_frame_pkg::R_W-1:0]   r_max,
  input  logic [bin_frame_pkg::G_W-1:0]   g_min,
  input  logic [bin_frame_pkg::G_W-1:0]   g_max,
  input  logic [bin_frame_pkg::B_W-1:0]   b_min,
  input  logic [bin_frame_pkg::B_W-1:0]   b_max,
  input  logic [bin_frame_pkg::PIX_W-1:0] pix_data,
  input  logic                            pix_valid,
  input  logic                            pix_sof,
  output logic                            pix_ready,
  output logic [ADDR_W-1:0]               addra,
  output logic [IMG_W-1:0]                dina,
  output logic                            ena,
  output logic                            wea,
  output logic                            bram_owner,
  output logic                            run_ed,
  input  logic                            finish_ed,
  output logic                            frame_done,
  output logic                            sync_err,
  output bin_frame_pkg::state_e           state_dbg
);

  import bin_frame_pkg::*;

  localparam int COL_W = $clog2(IMG_W);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 1);

  state_e            state;
  state_e            state_nxt;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] row;
  logic [IMG_W-1:0]  row_buf;
  logic              pix_bit;
  logic              accept;
  logic              sof_accept;
  logic              restart;

  rgb565_window u_window (
    .pix_data (pix_data),
    .r_min    (r_min),
    .r_max    (r_max),
    .g_min    (g_min),
    .g_max    (g_max),
    .b_min    (b_min),
    .b_max    (b_max),
    .hit      (pix_bit)
  );

  // Pixel handshake: a pixel transfers on a clock edge where pix_valid and pix_ready are both high;
  // pix_ready depends only on state, never on pix_valid, so the source may hold data for any time.
  assign pix_ready  = (state == WAIT_SOF) || (state == CAPTURE);
  assign accept     = pix_valid && pix_ready;
  assign sof_accept = accept && pix_sof;
  assign restart    = sof_accept && (state == CAPTURE) && ((col != '0) || (row != '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start && !finish_ed) state_nxt = WAIT_SOF;
      WAIT_SOF:  if (sof_accept) state_nxt = CAPTURE;
      CAPTURE:   if (accept && !pix_sof && (col == LAST_COL)) state_nxt = WRITE_ROW;
      WRITE_ROW: state_nxt = (row == LAST_ROW) ? HANDOFF : CAPTURE;
      HANDOFF:   state_nxt = RUN;
      RUN:       if (finish_ed) state_nxt = DONE;
      DONE:      if (!finish_ed) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // A start-of-frame pixel always lands in column 0 of row 0, whether it opens or restarts a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      row_buf    <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= (state == RUN) && finish_ed;
      sync_err   <= restart;
      case (state)
        IDLE: begin
          col <= '0;
          row <= '0;
        end
        WAIT_SOF: begin
          if (sof_accept) begin
            row_buf <= {{(IMG_W-1){1'b0}}, pix_bit};
            col     <= COL_W'(1);
            row     <= '0;
          end
        end
        CAPTURE: begin
          if (sof_accept) begin
            row_buf <= {{(IMG_W-1){1'b0}}, pix_bit};
            col     <= COL_W'(1);
            row     <= '0;
          end else if (accept) begin
            row_buf[col] <= pix_bit;
            if (col != LAST_COL) col <= col + 1'b1;
          end
        end
        WRITE_ROW: begin
          col <= '0;
          if (row != LAST_ROW) row <= row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ena        = (state == WRITE_ROW);
  assign wea        = (state == WRITE_ROW);
  assign addra      = (state == WRITE_ROW) ? row : '0;
  assign dina       = (state == WRITE_ROW) ? row_buf : '0;
  assign bram_owner = !((state == HANDOFF) || (state == RUN) || (state == DONE));
  assign run_ed     = (state == RUN);
  assign state_dbg  = state;

endmodule
